// File: rtl/riscv_pkg.sv
// Shared pipeline-control types for the RISC-V core.
// Contents:
//   fwd_sel_e  - operand-source select for the EX stage operand muxes
//   hz_state_e - hazard controller FSM states
//   CNT_MAX    - saturation value of the 16-bit event counters
//   sat_inc    - saturating increment helper for those counters
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,  // register file value
        FWD_EXMEM = 2'b01,  // EX_MEM ALU result
        FWD_MEMWB = 2'b10,  // MEM_WB result
        FWD_WB    = 2'b11   // WB holdover register
    } fwd_sel_e;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        FLUSH_PEND = 1'b1   // redirect seen during a memory stall, flush owed
    } hz_state_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding priority encoder for one EX operand.
// Ports:
//   use_rs    - in: the IF_ID instruction actually reads this operand
//   hit_idex  - in: source register matches ID_EX_rd (youngest producer)
//   hit_exmem - in: source register matches EX_MEM_rd
//   hit_memwb - in: source register matches MEM_WB_rd (oldest producer)
//   sel       - out: operand source select, fwd_sel_e encoding
// The youngest producer wins. Match flags for an unread operand are ignored.
module fwd_sel
    import riscv_pkg::*;
(
    input  logic       use_rs,
    input  logic       hit_idex,
    input  logic       hit_exmem,
    input  logic       hit_memwb,
    output logic [1:0] sel
);

    // Priority select; the youngest in-flight producer holds the newest value.
    always_comb begin
        sel = FWD_RF;
        if (!use_rs) begin
            sel = FWD_RF;
        end else if (hit_idex) begin
            sel = FWD_EXMEM;
        end else if (hit_exmem) begin
            sel = FWD_MEMWB;
        end else if (hit_memwb) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory
// freezes and registered forwarding selects for the EX stage.
// Ports:
//   clk, rst_n                 - clock (rising edge), async active-low reset
//   zero1/zero2                - IF_ID rs1/rs2 match ID_EX_rd
//   zero3/zero4                - IF_ID rs1/rs2 match EX_MEM_rd
//   zeroa/zerob                - IF_ID rs1/rs2 match MEM_WB_rd
//   uses_rs1/uses_rs2          - IF_ID instruction reads rs1/rs2
//   ID_EX_memread              - ID_EX holds a load
//   br_redirect                - taken branch/jump resolved in EX (pulse)
//   mem_stall                  - memory not ready, freeze everything
//   pc_we, if_id_we            - PC / IF_ID write enables
//   id_ex_bubble, if_id_flush  - insert bubble into ID_EX / squash IF_ID
//   fwd_a, fwd_b               - registered operand selects for EX
//   stall_cnt, flush_cnt       - saturating event counters
module hazard_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        zero1,
    input  logic        zero2,
    input  logic        zero3,
    input  logic        zero4,
    input  logic        zeroa,
    input  logic        zerob,
    input  logic        uses_rs1,
    input  logic        uses_rs2,
    input  logic        ID_EX_memread,
    input  logic        br_redirect,
    input  logic        mem_stall,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    hz_state_e   state_r;
    hz_state_e   next_state_s;
    logic        lu_hazard_s;
    logic        stall_ev_s;
    logic        pc_we_s;
    logic        if_id_we_s;
    logic        bubble_s;
    logic        flush_s;
    logic [1:0]  enc_a_s;
    logic [1:0]  enc_b_s;
    logic [1:0]  fwd_a_r;
    logic [1:0]  fwd_b_r;
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    assign lu_hazard_s = ID_EX_memread & ((zero1 & uses_rs1) | (zero2 & uses_rs2));

    fwd_sel u_fwd_a (
        .use_rs    (uses_rs1),
        .hit_idex  (zero1),
        .hit_exmem (zero3),
        .hit_memwb (zeroa),
        .sel       (enc_a_s)
    );

    fwd_sel u_fwd_b (
        .use_rs    (uses_rs2),
        .hit_idex  (zero2),
        .hit_exmem (zero4),
        .hit_memwb (zerob),
        .sel       (enc_b_s)
    );

    // FSM state register; reset drops any owed flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and pipeline controls. Priority: reset, memory freeze,
    // flush (owed or new), load-use stall, normal advance.
    always_comb begin
        next_state_s = state_r;
        pc_we_s      = 1'b1;
        if_id_we_s   = 1'b1;
        bubble_s     = 1'b0;
        flush_s      = 1'b0;
        stall_ev_s   = 1'b0;
        if (!rst_n) begin
            // Hold the front end quiet and the ID_EX slot empty while in reset.
            next_state_s = RUN;
            pc_we_s      = 1'b0;
            if_id_we_s   = 1'b0;
            bubble_s     = 1'b1;
            flush_s      = 1'b1;
        end else if (mem_stall) begin
            pc_we_s    = 1'b0;
            if_id_we_s = 1'b0;
            bubble_s   = 1'b0;
            flush_s    = 1'b0;
            // A redirect during a freeze must not be lost; remember it.
            if (br_redirect || (state_r == FLUSH_PEND)) begin
                next_state_s = FLUSH_PEND;
            end else begin
                next_state_s = RUN;
            end
        end else if (br_redirect || (state_r == FLUSH_PEND)) begin
            // Wrong-path instructions are squashed, so any load-use is moot.
            next_state_s = RUN;
            pc_we_s      = 1'b1;
            if_id_we_s   = 1'b1;
            bubble_s     = 1'b1;
            flush_s      = 1'b1;
        end else if (lu_hazard_s) begin
            next_state_s = RUN;
            pc_we_s      = 1'b0;
            if_id_we_s   = 1'b0;
            bubble_s     = 1'b1;
            stall_ev_s   = 1'b1;
        end else begin
            next_state_s = RUN;
        end
    end

    // Forwarding selects advance with the pipeline; a bubble carries no operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_r <= FWD_RF;
            fwd_b_r <= FWD_RF;
        end else if (!mem_stall) begin
            if (bubble_s) begin
                fwd_a_r <= FWD_RF;
                fwd_b_r <= FWD_RF;
            end else begin
                fwd_a_r <= enc_a_s;
                fwd_b_r <= enc_b_s;
            end
        end
    end

    // Saturating stall/flush event counters, frozen with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else if (!mem_stall) begin
            if (stall_ev_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign pc_we        = pc_we_s;
    assign if_id_we     = if_id_we_s;
    assign id_ex_bubble = bubble_s;
    assign if_id_flush  = flush_s;
    assign fwd_a        = fwd_a_r;
    assign fwd_b        = fwd_b_r;
    assign stall_cnt    = stall_cnt_r;
    assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change 1 time unit after a
// rising edge; combinational outputs are checked 1 unit after that, and
// registered outputs 1 unit after the following rising edge.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        zero1, zero2, zero3, zero4, zeroa, zerob;
    logic        uses_rs1, uses_rs2;
    logic        ID_EX_memread, br_redirect, mem_stall;
    logic        pc_we, if_id_we, id_ex_bubble, if_id_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .zero1         (zero1),
        .zero2         (zero2),
        .zero3         (zero3),
        .zero4         (zero4),
        .zeroa         (zeroa),
        .zerob         (zerob),
        .uses_rs1      (uses_rs1),
        .uses_rs2      (uses_rs2),
        .ID_EX_memread (ID_EX_memread),
        .br_redirect   (br_redirect),
        .mem_stall     (mem_stall),
        .pc_we         (pc_we),
        .if_id_we      (if_id_we),
        .id_ex_bubble  (id_ex_bubble),
        .if_id_flush   (if_id_flush),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the four pipeline controls together.
    task automatic chk_ctl(input string tag, input logic e_pc, input logic e_ifid,
                           input logic e_bub, input logic e_fl);
        chk1({tag, ".pc_we"}, pc_we, e_pc);
        chk1({tag, ".if_id_we"}, if_id_we, e_ifid);
        chk1({tag, ".bubble"}, id_ex_bubble, e_bub);
        chk1({tag, ".flush"}, if_id_flush, e_fl);
    endtask

    task automatic clr();
        zero1 = 1'b0; zero2 = 1'b0; zero3 = 1'b0; zero4 = 1'b0;
        zeroa = 1'b0; zerob = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0;
        ID_EX_memread = 1'b0; br_redirect = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        #3;
        // Reset state
        chk_ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1);
        chk2("reset.fwd_a", fwd_a, 2'b00);
        chk2("reset.fwd_b", fwd_b, 2'b00);
        chk16("reset.stall_cnt", stall_cnt, 16'd0);
        chk16("reset.flush_cnt", flush_cnt, 16'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Load-use on rs1: one-cycle stall, then forward from MEM_WB
        uses_rs1 = 1'b1; zero1 = 1'b1; ID_EX_memread = 1'b1;
        #1;
        chk_ctl("lu.c0", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk2("lu.c0.fwd_a", fwd_a, 2'b00);
        chk16("lu.c0.stall_cnt", stall_cnt, 16'd1);
        zero1 = 1'b0; ID_EX_memread = 1'b0; zero3 = 1'b1;
        #1;
        chk_ctl("lu.c1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk2("lu.c1.fwd_a", fwd_a, 2'b10);
        chk16("lu.c1.stall_cnt", stall_cnt, 16'd1);

        // ALU producer on rs2: ID_EX wins over EX_MEM, no stall
        clr();
        uses_rs2 = 1'b1; zero2 = 1'b1; zero4 = 1'b1;
        #1;
        chk_ctl("alu", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk2("alu.fwd_b", fwd_b, 2'b01);
        chk2("alu.fwd_a", fwd_a, 2'b00);

        // WB holdover on rs1; rs2 match ignored since rs2 unused
        clr();
        uses_rs1 = 1'b1; zeroa = 1'b1; zero2 = 1'b1; ID_EX_memread = 1'b1;
        #1;
        chk_ctl("wb", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk2("wb.fwd_a", fwd_a, 2'b11);
        chk2("wb.fwd_b", fwd_b, 2'b00);

        // Redirect together with load-use: flush wins, bubble zeroes selects
        clr();
        br_redirect = 1'b1; uses_rs1 = 1'b1; zero1 = 1'b1; zero3 = 1'b1;
        ID_EX_memread = 1'b1;
        #1;
        chk_ctl("brlu", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk2("brlu.fwd_a", fwd_a, 2'b00);
        chk16("brlu.flush_cnt", flush_cnt, 16'd1);
        chk16("brlu.stall_cnt", stall_cnt, 16'd1);

        // Preload fwd_a = 10 so the freeze is visible
        clr();
        uses_rs1 = 1'b1; zero3 = 1'b1;
        tick();
        chk2("pre.fwd_a", fwd_a, 2'b10);

        // Redirect during a 3-cycle memory stall: flush owed until release
        clr();
        br_redirect = 1'b1; mem_stall = 1'b1; uses_rs1 = 1'b1; zero1 = 1'b1;
        #1;
        chk_ctl("ms.c0", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        br_redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_ctl("ms.cn", 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk2("ms.fwd_a", fwd_a, 2'b10);
        chk16("ms.flush_cnt", flush_cnt, 16'd1);
        clr();
        #1;
        chk_ctl("ms.rel", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk16("ms.rel.flush_cnt", flush_cnt, 16'd2);
        chk2("ms.rel.fwd_a", fwd_a, 2'b00);
        chk_ctl("ms.after", 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset while a flush is owed: it must be discarded
        br_redirect = 1'b1; mem_stall = 1'b1;
        tick();
        br_redirect = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_ctl("rfp.inrst", 1'b0, 1'b0, 1'b1, 1'b1);
        chk16("rfp.flush_cnt", flush_cnt, 16'd0);
        chk16("rfp.stall_cnt", stall_cnt, 16'd0);
        tick();
        mem_stall = 1'b0;
        rst_n = 1'b1;
        #1;
        chk_ctl("rfp.rel", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk16("rfp.rel.flush_cnt", flush_cnt, 16'd0);

        // Stall counter saturation
        clr();
        uses_rs1 = 1'b1; zero1 = 1'b1; ID_EX_memread = 1'b1;
        repeat (65534) tick();
        chk16("sat.65534", stall_cnt, 16'hFFFE);
        tick();
        chk16("sat.65535", stall_cnt, 16'hFFFF);
        repeat (5) tick();
        chk16("sat.held", stall_cnt, 16'hFFFF);
        chk1("sat.pc_we", pc_we, 1'b0);
        chk16("sat.flush_cnt", flush_cnt, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
